ahb_slave_interconnect: RTL and testbench

AHB_SLAVE_INTERCONNECT -- requirements
Module: ahb_slave_interconnect

---
 rtl/ahb_slave_interconnect.sv | 154 +++++++++++++++
 tb/tb_ahb_slave_interconnect.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_interconnect.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_slave_interconnect
//  Purpose  : AHB address decoder and read-data/response multiplexer for
//             NUM_SLAVES memory slaves. It includes a built-in default slave
//             that answers unmapped NONSEQ/SEQ transfers with a two-cycle
//             ERROR response.
//  Ports    : HCLK, HRESETn (async, active-low)
//             HADDR, HTRANS, HWRITE        - master address phase
//             HSEL_S                       - one-hot slave selects
//             HRDATA_S, HRESP_S,
//             HREADYOUT_S                  - packed slave responses
//             HREADY, HRESP, HRDATA        - muxed data-phase response
//             err_count                    - ERROR response counter
//  Config   : define AHB_ERR_COUNT_EN to build the saturating error counter.
//             If it is not defined, err_count is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_slave_interconnect #(
    parameter int NUM_SLAVES      = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int SLAVE_ADDR_BITS = 10
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic [ADDR_WIDTH-1:0]            HADDR,
    input  logic [1:0]                       HTRANS,
    input  logic                             HWRITE,
    output logic [NUM_SLAVES-1:0]            HSEL_S,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]            HRESP_S,
    input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
    output logic                             HREADY,
    output logic                             HRESP,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic [15:0]                      err_count
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    // This limit has one extra bit, so the comparison is exact even when the
    // mapped region covers the whole HADDR range.
    localparam logic [ADDR_WIDTH:0] C_MAP_LIMIT =
        (ADDR_WIDTH+1)'(NUM_SLAVES) << SLAVE_ADDR_BITS;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    ds_state_t              r_ds, w_ds_next;
    logic                   r_dp_slave, w_dp_slave_next;
    logic [IDX_W-1:0]       r_dp_idx, w_dp_idx_next;

    logic [IDX_W-1:0]       w_idx;
    logic                   w_mapped;
    logic                   w_active;
    logic                   w_hready;
    logic                   w_hresp;
    logic [DATA_WIDTH-1:0]  w_hrdata;
    logic                   w_unused;

    // HWRITE passes through to the slaves directly. HTRANS[0] only tells
    // NONSEQ apart from SEQ, and BUSY apart from IDLE.
    assign w_unused = ^{HWRITE, HTRANS[0]};

    assign w_idx    = HADDR[SLAVE_ADDR_BITS +: IDX_W];
    // A mapped address always has w_idx < NUM_SLAVES. Index values past the
    // last slave are therefore rejected here as well.
    assign w_mapped = ({1'b0, HADDR} < C_MAP_LIMIT);
    assign w_active = HTRANS[1];

    always_comb begin
        HSEL_S = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            HSEL_S[i] = w_mapped && (w_idx == IDX_W'(i));
        end
    end

    // Data-phase response mux
    always_comb begin
        w_hready = 1'b1;
        w_hresp  = 1'b0;
        w_hrdata = '0;
        if (r_ds != DS_IDLE) begin
            w_hready = (r_ds == DS_ERR2);
            w_hresp  = 1'b1;
        end else if (r_dp_slave) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (r_dp_idx == IDX_W'(i)) begin
                    w_hready = HREADYOUT_S[i];
                    w_hresp  = HRESP_S[i];
                    w_hrdata = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign HREADY = w_hready;
    assign HRESP  = w_hresp;
    assign HRDATA = w_hrdata;

    // Next state for the data-phase select and the default-slave FSM
    always_comb begin
        w_ds_next       = r_ds;
        w_dp_slave_next = r_dp_slave;
        w_dp_idx_next   = r_dp_idx;
        if (r_ds == DS_ERR1) begin
            w_ds_next = DS_ERR2;
        end
        if (w_hready) begin
            w_dp_slave_next = w_active && w_mapped;
            w_dp_idx_next   = w_idx;
            if (w_active && !w_mapped) begin
                w_ds_next = DS_ERR1;
            end else if (r_ds == DS_ERR2) begin
                w_ds_next = DS_IDLE;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ds       <= DS_IDLE;
            r_dp_slave <= 1'b0;
            r_dp_idx   <= '0;
        end else begin
            r_ds       <= w_ds_next;
            r_dp_slave <= w_dp_slave_next;
            r_dp_idx   <= w_dp_idx_next;
        end
    end

`ifdef AHB_ERR_COUNT_EN
    logic [15:0] r_err_count;

    // The counter increments once per completed ERROR beat and saturates
    // at all ones.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_err_count <= 16'd0;
        end else if (w_hresp && w_hready && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_interconnect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_slave_interconnect
//  Purpose  : Directed self-checking bench for ahb_slave_interconnect, using
//             the default parameters (4 slaves with 1 KiB each).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_interconnect;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int AW = 32;

`ifdef AHB_ERR_COUNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             HCLK;
    logic             HRESETn;
    logic [AW-1:0]    HADDR;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic [NS-1:0]    HSEL_S;
    logic [NS*DW-1:0] HRDATA_S;
    logic [NS-1:0]    HRESP_S;
    logic [NS-1:0]    HREADYOUT_S;
    logic             HREADY;
    logic             HRESP;
    logic [DW-1:0]    HRDATA;
    logic [15:0]      err_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_errs = 0;

    ahb_slave_interconnect #(
        .NUM_SLAVES      (NS),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .SLAVE_ADDR_BITS (10)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSEL_S      (HSEL_S),
        .HRDATA_S    (HRDATA_S),
        .HRESP_S     (HRESP_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA),
        .err_count   (err_count)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk_err(input string tag);
        check(tag, {48'd0, err_count}, ERR_EN ? 64'(exp_errs) : 64'd0);
    endtask

    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

    initial begin
        HRESETn     = 1'b0;
        HADDR       = '0;
        HTRANS      = IDLE;
        HWRITE      = 1'b0;
        HRESP_S     = '0;
        HREADYOUT_S = '1;
        HRDATA_S    = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        #2;
        check("rst_hready", HREADY, 1);
        check("rst_hresp",  HRESP, 0);
        check("rst_hrdata", HRDATA, 0);
        chk_err("rst_err");
        tick();
        HRESETn = 1'b1;

        // Mapped read at 0xC04, which selects slave 3
        HADDR = 32'h0000_0C04; HTRANS = NONSEQ;
        #2;
        check("map_hsel", HSEL_S, 4'b1000);
        check("map_idle_hready", HREADY, 1);
        check("map_idle_hrdata", HRDATA, 0);
        tick();
        HADDR = 32'h0; HTRANS = IDLE;
        #2;
        check("map_hrdata", HRDATA, 32'h44444444);
        check("map_hready", HREADY, 1);
        check("hsel_idle_trans", HSEL_S, 4'b0001);
        HREADYOUT_S = 4'b0111;
        #1;
        check("map_hready_low", HREADY, 0);
        HREADYOUT_S = 4'b1111;
        HADDR = 32'h0000_0FFC;
        #1;
        check("top_mapped_hsel", HSEL_S, 4'b1000);
        HADDR = 32'h0;
        tick();
        #2;
        check("none_hrdata", HRDATA, 0);
        check("none_hready", HREADY, 1);

        // Unmapped access at the exact limit address 0x1000
        HADDR = 32'h0000_1000; HTRANS = NONSEQ;
        #2;
        check("unmap_hsel", HSEL_S, 4'b0000);
        tick();
        HADDR = 32'h0; HTRANS = IDLE;
        #2;
        check("err1_hready", HREADY, 0);
        check("err1_hresp",  HRESP, 1);
        check("err1_hrdata", HRDATA, 0);
        tick();
        #2;
        check("err2_hready", HREADY, 1);
        check("err2_hresp",  HRESP, 1);
        tick();
        exp_errs = 1;
        #2;
        check("post_err_hresp", HRESP, 0);
        check("post_err_hready", HREADY, 1);
        chk_err("unmap_err_count");

        // Wait-state hold: slave 1 stalls while slave 2 is presented
        HADDR = 32'h0000_0400; HTRANS = NONSEQ;
        tick();
        HREADYOUT_S = 4'b1101;
        HADDR = 32'h0000_0800; HTRANS = NONSEQ;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("wait_hready", HREADY, 0);
            check("wait_hrdata", HRDATA, 32'h22222222);
            tick();
        end
        HREADYOUT_S = 4'b1111;
        #2;
        check("wait_release_hready", HREADY, 1);
        check("wait_release_hrdata", HRDATA, 32'h22222222);
        tick();
        HTRANS = IDLE; HADDR = 32'h0;
        #2;
        check("wait_next_hrdata", HRDATA, 32'h33333333);
        tick();

        // Back-to-back: unmapped transfer, then SEQ to slave 1 accepted in DS_ERR2
        HADDR = 32'h0000_2000; HTRANS = NONSEQ;
        tick();
        HADDR = 32'h0000_0400; HTRANS = SEQ;
        #2;
        check("b2b_err1_hready", HREADY, 0);
        check("b2b_err1_hresp",  HRESP, 1);
        check("b2b_hsel", HSEL_S, 4'b0010);
        tick();
        #2;
        check("b2b_err2_hready", HREADY, 1);
        check("b2b_err2_hresp",  HRESP, 1);
        tick();
        exp_errs = 2;
        HTRANS = IDLE; HADDR = 32'h0;
        #2;
        check("b2b_hrdata", HRDATA, 32'h22222222);
        check("b2b_hresp",  HRESP, 0);
        check("b2b_hready", HREADY, 1);
        chk_err("b2b_err_count");
        HRESP_S = 4'b0010;
        #1;
        check("slave_err_pass", HRESP, 1);
        HRESP_S = 4'b0000;
        tick();

        // Reset asserted during DS_ERR1
        HADDR = 32'h0000_1000; HTRANS = NONSEQ;
        tick();
        HTRANS = IDLE; HADDR = 32'h0;
        #1;
        check("pre_rst_hready", HREADY, 0);
        HRESETn = 1'b0;
        exp_errs = 0;
        #1;
        check("midrst_hready", HREADY, 1);
        check("midrst_hresp",  HRESP, 0);
        chk_err("midrst_err");
        tick();
        HRESETn = 1'b1;
        tick();
        #2;
        check("after_rst_hready", HREADY, 1);
        check("after_rst_hresp",  HRESP, 0);
        check("after_rst_hrdata", HRDATA, 0);

`ifdef AHB_ERR_COUNT_EN
        // Saturation: slave 0 reports ERROR with ready on every beat
        HADDR = 32'h0; HTRANS = NONSEQ;
        tick();
        HRESP_S = 4'b0001;
        repeat (65540) tick();
        check("sat_err_count", {48'd0, err_count}, 64'hFFFF);
        HRESP_S = 4'b0000; HTRANS = IDLE;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
